// File: rtl/vedic_arith_pkg.sv
// Shared definitions for the Vedic arithmetic datapath: divider FSM states,
// default operand width and a constant-evaluable ceiling-log2 helper.
package vedic_arith_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } div_state_t;

   localparam int DW_DEFAULT = 8;

   // Ceiling log2, used to size the iteration counter at elaboration time.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         result++;
      end
      return result;
   endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, keep the result if it fits.
// Purely combinational so it can be chained to retire several bits per cycle.
module div_step #(
   parameter int DW = 8
) (
   input  logic [DW-1:0] r_in,
   input  logic          q_msb,
   input  logic [DW-1:0] d,
   output logic [DW-1:0] r_out,
   output logic          q_bit
);

   logic [DW:0] trial;

   // Trial subtraction; the compare needs the full DW+1 bit trial value.
   always_comb begin
      trial = {r_in, q_msb};
      q_bit = (trial >= {1'b0, d});
      // When the subtract is taken the exact result is below d, so it fits in
      // DW bits and the low DW bits of the wrapped difference are exact.
      r_out = q_bit ? (trial[DW-1:0] - d) : trial[DW-1:0];
   end

endmodule

// File: rtl/vedic_div_16by8.sv
// Sequential restoring divider: 2*DW-bit dividend by DW-bit divisor, one
// quotient bit per clock, valid/ready on both sides. Divide-by-zero returns
// an all-ones quotient and the low dividend byte as remainder.
module vedic_div_16by8
   import vedic_arith_pkg::*;
#(
   parameter int DW = DW_DEFAULT
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2*DW-1:0] dividend,
   input  logic [DW-1:0]   divisor,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [2*DW-1:0] quotient,
   output logic [DW-1:0]   remainder,
   output logic            div_by_zero
);

   localparam int CW = clog2(2 * DW) + 1;

   div_state_t      state, state_next;
   logic [2*DW-1:0] q_reg;
   logic [DW-1:0]   d_reg;
   // Partial remainder is always below the divisor between iterations, so DW
   // bits hold it; the DW+1 bit trial value lives inside div_step.
   logic [DW-1:0]   r_reg;
   logic [CW-1:0]   cnt;
   logic            dbz_reg;
   logic [DW-1:0]   r_next;
   logic            q_bit;

   div_step #(.DW(DW)) u_step (
      .r_in  (r_reg),
      .q_msb (q_reg[2*DW-1]),
      .d     (d_reg),
      .r_out (r_next),
      .q_bit (q_bit)
   );

   // State register.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and handshake decode.
   // NOTE: every output of this block gets a default first so no path leaves
   // it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_next = (divisor == '0) ? DONE : CALC;
            end
         end
         CALC: begin
            if (cnt == CW'(1)) begin
               state_next = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Operand capture, iteration and result hold.
   // NOTE: these are a handful of datapath flops, not a memory array, so they
   // are reset to give the defined all-zero outputs straight out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_reg   <= '0;
         d_reg   <= '0;
         r_reg   <= '0;
         cnt     <= '0;
         dbz_reg <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  d_reg <= divisor;
                  cnt   <= CW'(2 * DW);
                  if (divisor == '0) begin
                     q_reg   <= '1;
                     r_reg   <= dividend[DW-1:0];
                     dbz_reg <= 1'b1;
                  end else begin
                     q_reg   <= dividend;
                     r_reg   <= '0;
                     dbz_reg <= 1'b0;
                  end
               end
            end
            CALC: begin
               q_reg <= {q_reg[2*DW-2:0], q_bit};
               r_reg <= r_next;
               cnt   <= cnt - CW'(1);
            end
            DONE: begin
               if (out_ready) begin
                  dbz_reg <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign quotient    = q_reg;
   assign remainder   = r_reg;
   assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_vedic_div_16by8.sv
// Self-checking bench for vedic_div_16by8: directed corner cases plus a
// randomized back-to-back run against a plain / and % reference model.
module tb_vedic_div_16by8;

   localparam int DW      = 8;
   localparam int LAT     = 2 * DW + 1;
   localparam int N_RAND  = 500;

   logic            clk;
   logic            rst_n;
   logic            in_valid;
   logic            in_ready;
   logic [2*DW-1:0] dividend;
   logic [DW-1:0]   divisor;
   logic            out_valid;
   logic            out_ready;
   logic [2*DW-1:0] quotient;
   logic [DW-1:0]   remainder;
   logic            div_by_zero;

   int checks;
   int errors;

   vedic_div_16by8 #(.DW(DW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .dividend    (dividend),
      .divisor     (divisor),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model straight from the arithmetic definition.
   function automatic logic [2*DW-1:0] ref_quot(input logic [2*DW-1:0] a, input logic [DW-1:0] b);
      if (b == 0) return '1;
      return a / b;
   endfunction

   function automatic logic [DW-1:0] ref_rem(input logic [2*DW-1:0] a, input logic [DW-1:0] b);
      logic [2*DW-1:0] r;
      if (b == 0) return a[DW-1:0];
      r = a % b;
      return r[DW-1:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present operands, wait for acceptance, then measure latency and check the result.
   task automatic start_op(input logic [2*DW-1:0] a, input logic [DW-1:0] b, input string tag);
      int waited;
      int lat;
      in_valid = 1'b1;
      dividend = a;
      divisor  = b;
      waited   = 0;
      while (!in_ready && waited < 100) begin
         tick();
         waited++;
      end
      check({tag, "_accept_timeout"}, 32'(waited < 100), 32'd1);
      tick();
      in_valid = 1'b0;
      dividend = $urandom();
      divisor  = $urandom();
      lat = 1;
      while (!out_valid && lat < 100) begin
         tick();
         lat++;
      end
      check({tag, "_latency"}, 32'(lat), (b == 0) ? 32'd1 : 32'(LAT));
      check({tag, "_quot"}, 32'(quotient), 32'(ref_quot(a, b)));
      check({tag, "_rem"}, 32'(remainder), 32'(ref_rem(a, b)));
      check({tag, "_dbz"}, 32'(div_by_zero), 32'(b == 0));
   endtask

   // Consume the held result and confirm the return to idle.
   task automatic finish_op(input string tag);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, "_valid_clr"}, 32'(out_valid), 32'd0);
      check({tag, "_dbz_clr"}, 32'(div_by_zero), 32'd0);
      check({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      logic [2*DW-1:0] exp_q [$];
      logic [DW-1:0]   exp_r [$];
      logic [2*DW-1:0] cur_a;
      logic [DW-1:0]   cur_b;
      int              sent;
      int              recv;
      int              cyc;

      checks    = 0;
      errors    = 0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      dividend  = '0;
      divisor   = '0;
      rst_n     = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();

      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_quot", 32'(quotient), 32'd0);
      check("rst_rem", 32'(remainder), 32'd0);
      check("rst_dbz", 32'(div_by_zero), 32'd0);

      // Round trips of multiplier products.
      start_op(16'd2795, 8'd43, "rt_2795_43");  finish_op("rt_2795_43");
      start_op(16'd1081, 8'd47, "rt_1081_47");  finish_op("rt_1081_47");
      start_op(16'd1395, 8'd31, "rt_1395_31");  finish_op("rt_1395_31");

      // Nonzero remainder and extremes.
      start_op(16'd1000, 8'd7, "d_1000_7");     finish_op("d_1000_7");
      start_op(16'hFFFF, 8'd1, "d_ffff_1");     finish_op("d_ffff_1");
      start_op(16'hFFFF, 8'd255, "d_ffff_255"); finish_op("d_ffff_255");
      start_op(16'd5, 8'd200, "d_5_200");       finish_op("d_5_200");

      // Divide by zero followed by a normal operation.
      start_op(16'd1234, 8'd0, "dz_1234");      finish_op("dz_1234");
      start_op(16'd10, 8'd3, "d_10_3");         finish_op("d_10_3");

      // Backpressure with a competing request during the stall.
      start_op(16'd1000, 8'd7, "bp_1000_7");
      for (int i = 0; i < 6; i++) begin
         if (i == 1) begin
            in_valid = 1'b1;
            dividend = 16'd10;
            divisor  = 8'd3;
         end
         check("bp_valid", 32'(out_valid), 32'd1);
         check("bp_in_ready", 32'(in_ready), 32'd0);
         check("bp_quot", 32'(quotient), 32'd142);
         check("bp_rem", 32'(remainder), 32'd6);
         tick();
      end
      finish_op("bp_1000_7");
      start_op(16'd10, 8'd3, "bp_next_10_3");
      finish_op("bp_next_10_3");

      // Asynchronous reset in the middle of a calculation.
      in_valid = 1'b1;
      dividend = 16'd60000;
      divisor  = 8'd13;
      tick();
      in_valid = 1'b0;
      repeat (7) tick();
      check("mid_busy", 32'(in_ready), 32'd0);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_in_ready", 32'(in_ready), 32'd1);
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_quot", 32'(quotient), 32'd0);
      check("mid_rst_rem", 32'(remainder), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      check("mid_rel_in_ready", 32'(in_ready), 32'd1);
      start_op(16'd60000, 8'd13, "mid_redo");
      finish_op("mid_redo");

      // Randomized back-to-back run with random output backpressure.
      sent  = 0;
      recv  = 0;
      cyc   = 0;
      cur_a = 16'($urandom_range(0, 65535));
      cur_b = 8'($urandom_range(1, 255));
      while (recv < N_RAND && cyc < 40000) begin
         in_valid  = (sent < N_RAND);
         dividend  = cur_a;
         divisor   = cur_b;
         out_ready = 1'($urandom_range(0, 1));
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("rand_dup_result", 32'd1, 32'd0);
            end else begin
               check("rand_quot", 32'(quotient), 32'(exp_q.pop_front()));
               check("rand_rem", 32'(remainder), 32'(exp_r.pop_front()));
               check("rand_dbz", 32'(div_by_zero), 32'd0);
            end
            recv++;
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(ref_quot(cur_a, cur_b));
            exp_r.push_back(ref_rem(cur_a, cur_b));
            sent++;
            cur_a = 16'($urandom_range(0, 65535));
            cur_b = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 7)) : 8'($urandom_range(1, 255));
         end
         tick();
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("rand_count", 32'(recv), 32'(N_RAND));
      check("rand_leftover", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
